// File: rtl/rr_grant_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM state encoding
// and any constants common to the arbiter family.
package rr_grant_arb_pkg;

  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_GRANTED = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE    = ARB_IDLE,
    ST_GRANTED = ARB_GRANTED
  } arb_state_e;

endpackage

// File: rtl/rr_grant_arb_pos2bin.sv
// One-hot position to binary index encoder with multi-hot / no-hot flags.
// The index is the OR of all set positions, so it is only meaningful when one-hot.
module pos2bin
  import rr_grant_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BIN_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     pos,
  output logic [BIN_WIDTH-1:0] bin,
  output logic                 err_multi_hot,
  output logic                 err_no_hot
);

  localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1'b1);

  // OR together the indices of every set position
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin = bin | ({BIN_WIDTH{pos[i]}} & BIN_WIDTH'(i));
    end
  end

  assign err_no_hot    = (pos == '0);
  assign err_multi_hot = ((pos & (pos - POS_ONE)) != '0);

endmodule

// File: rtl/rr_grant_arb.sv
// Round-robin arbiter with registered one-hot grant, release/drop handover
// without bubbles, and an optional maximum hold time.
module rr_grant_arb
  import rr_grant_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BIN_WIDTH = $clog2(WIDTH),
  parameter int MAX_HOLD  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic                 release_grant,
  output logic [WIDTH-1:0]     grant,
  output logic                 grant_valid,
  output logic [BIN_WIDTH-1:0] grant_bin,
  output logic                 timeout,
  output logic                 grant_err
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0]     HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1'b1);
  localparam logic [BIN_WIDTH-1:0] BIN_ONE   = BIN_WIDTH'(1'b1);
  localparam logic [WIDTH-1:0]     VEC_ONE   = WIDTH'(1'b1);

  arb_state_e           state_r;
  logic [BIN_WIDTH-1:0] ptr_r;
  logic [WIDTH-1:0]     grant_r;
  logic                 grant_valid_r;
  logic                 timeout_r;
  logic [CNT_W-1:0]     hold_cnt_r;

  logic [BIN_WIDTH-1:0] owner_bin_s;
  logic [BIN_WIDTH-1:0] next_ptr_s;
  logic                 err_multi_s;
  logic                 err_none_s;
  logic                 granted_s;
  logic                 owner_req_s;
  logic                 expire_s;
  logic                 end_own_s;
  logic                 timeout_s;
  logic [WIDTH-1:0]     arb_req_s;
  logic [BIN_WIDTH-1:0] arb_ptr_s;
  logic [WIDTH-1:0]     rot_s;
  logic [WIDTH-1:0]     first_s;
  logic [WIDTH-1:0]     win_s;

  pos2bin #(
    .WIDTH     (WIDTH),
    .BIN_WIDTH (BIN_WIDTH)
  ) u_pos2bin (
    .pos           (grant_r),
    .bin           (owner_bin_s),
    .err_multi_hot (err_multi_s),
    .err_no_hot    (err_none_s)
  );

  assign granted_s   = (state_r == ST_GRANTED);
  assign owner_req_s = |(req & grant_r);
  assign expire_s    = (MAX_HOLD > 0) && granted_s && (hold_cnt_r == HOLD_LAST);
  assign end_own_s   = granted_s && (release_grant || !owner_req_s || expire_s);
  // A release in the same cycle as expiry wins, so no timeout pulse then
  assign timeout_s   = expire_s && owner_req_s && !release_grant;
  assign next_ptr_s  = owner_bin_s + BIN_ONE;

  // Circular priority search: rotate by the pointer, pick lowest set bit, rotate back
  always_comb begin
    arb_req_s = req;
    arb_ptr_s = ptr_r;
    if (granted_s) begin
      arb_req_s = req & ~grant_r;
      arb_ptr_s = next_ptr_s;
    end else begin
      arb_req_s = req;
      arb_ptr_s = ptr_r;
    end
    rot_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rot_s[i] = arb_req_s[BIN_WIDTH'(i) + arb_ptr_s];
    end
    first_s = rot_s & (~rot_s + VEC_ONE);
    win_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      win_s[BIN_WIDTH'(i) + arb_ptr_s] = first_s[i];
    end
  end

  // Grant FSM, pointer, hold counter and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
      hold_cnt_r    <= '0;
    end else begin
      timeout_r <= timeout_s;
      case (state_r)
        ST_IDLE: begin
          hold_cnt_r <= '0;
          if (|req) begin
            grant_r       <= win_s;
            grant_valid_r <= 1'b1;
            state_r       <= ST_GRANTED;
          end else begin
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        ST_GRANTED: begin
          if (end_own_s) begin
            ptr_r      <= next_ptr_s;
            hold_cnt_r <= '0;
            if (|arb_req_s) begin
              grant_r       <= win_s;
              grant_valid_r <= 1'b1;
              state_r       <= ST_GRANTED;
            end else begin
              grant_r       <= '0;
              grant_valid_r <= 1'b0;
              state_r       <= ST_IDLE;
            end
          end else if (hold_cnt_r != HOLD_SAT) begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          grant_r       <= '0;
          grant_valid_r <= 1'b0;
          hold_cnt_r    <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_bin   = owner_bin_s;
  assign timeout     = timeout_r;
  assign grant_err   = err_multi_s | (err_none_s & grant_valid_r);

endmodule

// File: tb/tb_rr_grant_arb.sv
// Directed and randomized checks of rr_grant_arb with MAX_HOLD=0 and MAX_HOLD=4.
module tb_rr_grant_arb;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        rel;

  logic [15:0] g0, g4;
  logic        v0, v4, t0, t4, e0, e4;
  logic [3:0]  b0, b4;

  int total;
  int bad;

  rr_grant_arb #(.WIDTH(16), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .release_grant(rel),
    .grant(g0), .grant_valid(v0), .grant_bin(b0), .timeout(t0), .grant_err(e0)
  );

  rr_grant_arb #(.WIDTH(16), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .release_grant(rel),
    .grant(g4), .grant_valid(v4), .grant_bin(b4), .timeout(t4), .grant_err(e4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 16'h0000;
    rel = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int          wait_cnt [16];
  logic [15:0] prev_g;
  logic        unfair;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 16'h0000;
    rel   = 1'b0;

    tick();
    check_val("rst_grant", g0, 16'h0000);
    check_val("rst_valid", v0, 1'b0);
    check_val("rst_timeout", t0, 1'b0);
    check_val("rst_err", e0, 1'b0);
    check_val("rst_grant4", g4, 16'h0000);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("idle_grant", g0, 16'h0000);
      check_val("idle_valid", v0, 1'b0);
      check_val("idle_bin", b0, 4'd0);
      check_val("idle_err", e0, 1'b0);
    end

    // Two requesters, release every third cycle: strict alternation, no bubbles
    do_reset();
    req = 16'h0011;
    for (int k = 0; k < 12; k++) begin
      rel = (k > 0) && (k % 3 == 0);
      tick();
      check_val("alt_grant", g0, ((k / 3) % 2 == 0) ? 16'h0001 : 16'h0010);
      check_val("alt_bin", b0, ((k / 3) % 2 == 0) ? 4'd0 : 4'd4);
      check_val("alt_valid", v0, 1'b1);
    end
    rel = 1'b0;

    // Wrap from bit15 to bit0 and back
    do_reset();
    req = 16'h8000;
    tick();
    check_val("own15", g0, 16'h8000);
    check_val("own15_bin", b0, 4'd15);
    req = 16'h8001;
    rel = 1'b1;
    tick();
    check_val("wrap_bit0", g0, 16'h0001);
    tick();
    check_val("served_bit15", g0, 16'h8000);
    check_val("served_bin", b0, 4'd15);
    req = 16'h8000;
    tick();
    check_val("no_regrant", g0, 16'h0000);
    check_val("no_regrant_v", v0, 1'b0);
    rel = 1'b0;
    tick();
    check_val("regrant_later", g0, 16'h8000);
    req = 16'h0002;
    tick();
    check_val("owner_drop", g0, 16'h0002);
    req = 16'hfff2;
    tick();
    check_val("nonowner_hold1", g0, 16'h0002);
    tick();
    check_val("nonowner_hold2", g0, 16'h0002);
    req = 16'h0000;
    tick();
    check_val("drop_idle", g0, 16'h0000);
    check_val("drop_idle_v", v0, 1'b0);

    // Hold limit of 4 on dut4; dut0 has no limit
    do_reset();
    req = 16'h0004;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("hold_grant", g4, 16'h0004);
      check_val("hold_to", t4, 1'b0);
    end
    tick();
    check_val("to_grant", g4, 16'h0000);
    check_val("to_valid", v4, 1'b0);
    check_val("to_pulse", t4, 1'b1);
    check_val("nolimit_grant", g0, 16'h0004);
    check_val("nolimit_to", t0, 1'b0);
    tick();
    check_val("to_regrant", g4, 16'h0004);
    check_val("to_pulse_end", t4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("hold2_grant", g4, 16'h0004);
    end
    rel = 1'b1;
    tick();
    check_val("rel_vs_to_grant", g4, 16'h0000);
    check_val("rel_vs_to_pulse", t4, 1'b0);
    rel = 1'b0;

    // Reset mid-grant, then pointer restart at 0
    do_reset();
    req = 16'h0300;
    tick();
    check_val("pre_rst", g0, 16'h0100);
    rst = 1'b1;
    rel = 1'b1;
    tick();
    check_val("mid_rst_grant", g0, 16'h0000);
    check_val("mid_rst_valid", v0, 1'b0);
    rst = 1'b0;
    rel = 1'b0;
    tick();
    check_val("post_rst", g0, 16'h0100);
    rel = 1'b1;
    tick();
    check_val("to_bit9", g0, 16'h0200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rel = 1'b0;
    tick();
    check_val("ptr_reset", g0, 16'h0100);

    // Random run: one-hot-or-zero, no error flag, bounded wait in grants
    do_reset();
    prev_g = 16'h0000;
    for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      rel = ($urandom_range(0, 5) == 0);
      tick();
      unfair = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (!req[i]) wait_cnt[i] = 0;
        else if (v0 && (g0 != prev_g)) wait_cnt[i] = g0[i] ? 0 : wait_cnt[i] + 1;
        if (wait_cnt[i] > 16) unfair = 1'b1;
      end
      prev_g = g0;
      check_val("rnd_onehot0", $onehot0(g0), 1'b1);
      check_val("rnd_valid", v0, (g0 != 16'h0000));
      check_val("rnd_err", e0, 1'b0);
      check_val("rnd_err4", e4, 1'b0);
      check_val("rnd_fair", unfair, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
